eth_rx_dispatch: RTL

Receive-side counterpart of the ARP/UDP transmit arbiter. Takes the raw GMII receive stream and classifies each frame by preamble/SFD, destination MAC and EtherType. Forwards each accepted frame unmodified, preamble included, to exactly one of the ARP receiver or the UDP receiver. All other frames are discarded. Sits between the GMII RX interface and the ARP/UDP receive modules, in the same clock domain.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/route_fifo.sv | 39 +++
 rtl/eth_rx_dispatch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: route classes, framing constants and a MAC byte helper.
package eth_pkg;

  typedef enum logic [1:0] {
    ROUTE_DROP = 2'd0,
    ROUTE_ARP  = 2'd1,
    ROUTE_UDP  = 2'd2
  } route_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam int unsigned ETH_HDR_LEN   = 22;
  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;

  // Byte idx of a MAC in wire order (idx 0 is the most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << (int'(idx) * 8);
    return sh[47:40];
  endfunction

endpackage

// File: rtl/route_fifo.sv
// Small synchronous FIFO holding one route decision per frame in flight.
module route_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign rdata = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/eth_rx_dispatch.sv
// GMII receive dispatcher: classifies each frame and forwards it unmodified to ARP or UDP.
// Optional per-class frame counters are built when RX_STAT_EN is defined.
module eth_rx_dispatch
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC    = 48'h00_11_22_33_44_55,
  parameter logic [15:0] ETH_TYPE_ARP = ETHERTYPE_ARP,
  parameter logic [15:0] ETH_TYPE_IP  = ETHERTYPE_IP,
  parameter int unsigned DLY          = ETH_HDR_LEN,
  parameter int unsigned RQ_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_gmii_rx_dv,
  output logic [7:0]  arp_gmii_rxd,
  output logic        udp_gmii_rx_dv,
  output logic [7:0]  udp_gmii_rxd,
  output logic        frame_drop
`ifdef RX_STAT_EN
  ,
  output logic [15:0] arp_frame_cnt,
  output logic [15:0] udp_frame_cnt,
  output logic [15:0] drop_frame_cnt
`endif
);

  localparam logic [5:0] LastHdrIdx = 6'(ETH_HDR_LEN - 1);
  localparam logic [5:0] TypeHiIdx  = 6'(ETH_HDR_LEN - 2);

  logic [8:0] dly_q [DLY];
  logic [5:0] bcnt_q;
  logic       pre_ok_q, ucast_q, bcast_q;
  logic       pre_ok_d, ucast_d, bcast_d;
  logic [7:0] type_hi_q;
  logic       tail_last_q;
  logic       first, in_hdr, is_dst, byte_pre_ok;
  logic [7:0] mac_exp;
  route_e     push_route;
  logic       push, pop, full, empty;
  logic [1:0] head;
  logic       tail_dv;
  logic [7:0] tail_data;
  logic       arp_sel, udp_sel;

  // Unicast and broadcast matches are tracked separately so a mixed address cannot pass.
  always_comb begin
    first  = (bcnt_q == 6'd0);
    in_hdr = gmii_rx_dv && (bcnt_q <= LastHdrIdx);
    is_dst = (bcnt_q >= 6'd8) && (bcnt_q <= 6'd13);
    mac_exp = mac_byte(BOARD_MAC, 3'(bcnt_q - 6'd8));
    if (bcnt_q < 6'd7)       byte_pre_ok = (gmii_rxd == ETH_PREAMBLE);
    else if (bcnt_q == 6'd7) byte_pre_ok = (gmii_rxd == ETH_SFD);
    else                     byte_pre_ok = 1'b1;
    pre_ok_d = (first | pre_ok_q) & byte_pre_ok;
    ucast_d  = (first | ucast_q) & (~is_dst | (gmii_rxd == mac_exp));
    bcast_d  = (first | bcast_q) & (~is_dst | (gmii_rxd == 8'hFF));

    push       = 1'b0;
    push_route = ROUTE_DROP;
    if (gmii_rx_dv && (bcnt_q == LastHdrIdx)) begin
      push = 1'b1;
      if (pre_ok_d && (ucast_d || bcast_d)) begin
        if ({type_hi_q, gmii_rxd} == ETH_TYPE_ARP)     push_route = ROUTE_ARP;
        else if ({type_hi_q, gmii_rxd} == ETH_TYPE_IP) push_route = ROUTE_UDP;
      end
    end else if (!gmii_rx_dv && !first && (bcnt_q <= LastHdrIdx)) begin
      push = 1'b1;  // runt frame ended before the decision byte
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q    <= '0;
      pre_ok_q  <= 1'b0;
      ucast_q   <= 1'b0;
      bcast_q   <= 1'b0;
      type_hi_q <= '0;
    end else begin
      if (gmii_rx_dv) bcnt_q <= (bcnt_q == 6'd63) ? bcnt_q : bcnt_q + 6'd1;
      else            bcnt_q <= '0;
      if (in_hdr) begin
        pre_ok_q <= pre_ok_d;
        ucast_q  <= ucast_d;
        bcast_q  <= bcast_d;
      end
      if (gmii_rx_dv && (bcnt_q == TypeHiIdx)) type_hi_q <= gmii_rxd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {gmii_rx_dv, gmii_rxd};
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  route_fifo #(
    .Width(2),
    .Depth(RQ_DEPTH)
  ) u_route_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(push_route),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign tail_dv   = dly_q[DLY-1][8];
  assign tail_data = dly_q[DLY-1][7:0];
  assign pop       = tail_last_q & ~tail_dv & ~empty;
  assign arp_sel   = tail_dv & ~empty & (head == ROUTE_ARP);
  assign udp_sel   = tail_dv & ~empty & (head == ROUTE_UDP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_last_q    <= 1'b0;
      arp_gmii_rx_dv <= 1'b0;
      arp_gmii_rxd   <= '0;
      udp_gmii_rx_dv <= 1'b0;
      udp_gmii_rxd   <= '0;
      frame_drop     <= 1'b0;
    end else begin
      tail_last_q    <= tail_dv;
      arp_gmii_rx_dv <= arp_sel;
      arp_gmii_rxd   <= arp_sel ? tail_data : 8'h00;
      udp_gmii_rx_dv <= udp_sel;
      udp_gmii_rxd   <= udp_sel ? tail_data : 8'h00;
      frame_drop     <= (pop && (head == ROUTE_DROP)) || (push && full);
    end
  end

`ifdef RX_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_frame_cnt  <= '0;
      udp_frame_cnt  <= '0;
      drop_frame_cnt <= '0;
    end else if (pop) begin
      if ((head == ROUTE_ARP) && (arp_frame_cnt != 16'hFFFF))
        arp_frame_cnt <= arp_frame_cnt + 16'd1;
      if ((head == ROUTE_UDP) && (udp_frame_cnt != 16'hFFFF))
        udp_frame_cnt <= udp_frame_cnt + 16'd1;
      if ((head == ROUTE_DROP) && (drop_frame_cnt != 16'hFFFF))
        drop_frame_cnt <= drop_frame_cnt + 16'd1;
    end
  end
`endif

endmodule
